// File: rtl/wb_pkg.sv
// Writeback arbiter shared definitions: widths, result payload type and kill lookup.
package wb_pkg;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_LEN   = 32;
    localparam int unsigned ROB_IDX_W = $clog2(ROB_LEN);
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned RR_PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // One functional-unit result as held in a writeback buffer.
    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    P_rd;
    } wb_req_t;

    // True when the ROB entry is squashed by the active kill mask.
    function automatic logic rob_killed(input logic [ROB_LEN-1:0]   kill,
                                        input logic [ROB_IDX_W-1:0] idx);
        return kill[idx];
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: FU result requests, flush controls and the shared WB port.
//   master : FU/ROB side (drives requests and flush controls, observes WB port)
//   slave  : arbiter side
interface wb_arbiter_if;
    import wb_pkg::*;

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*XLEN-1:0]      req_data;
    logic [N_REQ*ROB_IDX_W-1:0] req_rob_idx;
    logic [N_REQ*PREG_W-1:0]    req_P_rd;
    logic                       mispredict;
    logic [ROB_LEN-1:0]         flush_mask;
    logic                       stall;
    logic                       WB_valid;
    logic [XLEN-1:0]            WB_data;
    logic [ROB_IDX_W-1:0]       WB_rob_idx;
    logic [PREG_W-1:0]          WB_P_rd;
    logic                       WB_wen;
    logic [N_REQ-1:0]           WB_grant;

    modport master (
        output req_valid, req_data, req_rob_idx, req_P_rd, mispredict, flush_mask, stall,
        input  req_ready, WB_valid, WB_data, WB_rob_idx, WB_P_rd, WB_wen, WB_grant
    );

    modport slave (
        input  req_valid, req_data, req_rob_idx, req_P_rd, mispredict, flush_mask, stall,
        output req_ready, WB_valid, WB_data, WB_rob_idx, WB_P_rd, WB_wen, WB_grant
    );

endinterface

// File: rtl/rr_arbiter.sv
// N-input round-robin arbiter: first requester at or after ptr (mod N) wins.
//   req      : request vector
//   ptr      : highest-priority index
//   grant_c  : one-hot winner (zero when no request)
//   winner_c : winner index (zero when no request)
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [PW-1:0] winner_c
);

    int unsigned idx;
    logic        found;

    // Rotating scan; the first hit in priority order locks the grant.
    always_comb begin
        grant_c  = '0;
        winner_c = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                grant_c[idx] = 1'b1;
                winner_c     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the ROB/PRF writeback port among N_REQ FU result streams.
// Each unit has a one-entry buffer; a round-robin arbiter picks one buffered
// result per cycle, and results of squashed ROB entries are dropped.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_arbiter_if.slave (requests, flush controls, WB port)
module wb_arbiter
    import wb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_req_t               buf_q [N_REQ];
    logic [N_REQ-1:0]      buf_valid;
    logic [RR_PTR_W-1:0]   rr_ptr;
    logic [ROB_LEN-1:0]    flush_mask_r;

    logic [ROB_LEN-1:0]    kill;
    wb_req_t               req_in [N_REQ];
    logic [N_REQ-1:0]      buf_killed;
    logic [N_REQ-1:0]      in_killed;
    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      req_ready;
    logic [RR_PTR_W-1:0]   winner;
    logic [RR_PTR_W-1:0]   next_ptr;
    wb_req_t               wb_sel;

    // Kill mask, input unpacking and per-buffer eligibility.
    // Eligibility is suppressed during reset so no WB pulse leaks out.
    always_comb begin
        kill = flush_mask_r;
        if (bus.mispredict) begin
            kill = kill | bus.flush_mask;
        end
        buf_killed = '0;
        in_killed  = '0;
        eligible   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_in[i].data    = bus.req_data[i*XLEN +: XLEN];
            req_in[i].rob_idx = bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            req_in[i].P_rd    = bus.req_P_rd[i*PREG_W +: PREG_W];
            buf_killed[i]     = buf_valid[i] && rob_killed(kill, buf_q[i].rob_idx);
            in_killed[i]      = rob_killed(kill, req_in[i].rob_idx);
            eligible[i]       = buf_valid[i] && !buf_killed[i] && !rst;
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req      (eligible),
        .ptr      (rr_ptr),
        .grant_c  (grant),
        .winner_c (winner)
    );

    // Winner index is 0 when nothing is granted, so idle WB data shows buffer 0.
    always_comb begin
        wb_sel    = buf_q[winner];
        next_ptr  = RR_PTR_W'((32'(winner) + 32'd1) % N_REQ);
        req_ready = ~buf_valid | grant | buf_killed;
    end

    assign bus.req_ready  = req_ready;
    assign bus.WB_valid   = |grant;
    assign bus.WB_data    = wb_sel.data;
    assign bus.WB_rob_idx = wb_sel.rob_idx;
    assign bus.WB_P_rd    = wb_sel.P_rd;
    assign bus.WB_wen     = (|grant) && (wb_sel.P_rd != '0);
    assign bus.WB_grant   = grant;

    // Buffers, round-robin pointer and held flush mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid    <= '0;
            rr_ptr       <= '0;
            flush_mask_r <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && req_ready[i]) begin
                    // A result for an already-squashed entry is accepted and dropped.
                    buf_valid[i] <= !in_killed[i];
                    buf_q[i]     <= req_in[i];
                end else if (grant[i] || buf_killed[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            if (|grant) begin
                rr_ptr <= next_ptr;
            end
            if (bus.mispredict) begin
                flush_mask_r <= bus.flush_mask;
            end else if (!bus.stall) begin
                flush_mask_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// sequences and randomized traffic against a behavioural reference model.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic                 mv [N_REQ];
    logic [XLEN-1:0]      md [N_REQ];
    logic [ROB_IDX_W-1:0] mr [N_REQ];
    logic [PREG_W-1:0]    mp [N_REQ];
    int                   mptr;
    logic [ROB_LEN-1:0]   mflush;
    logic [ROB_LEN-1:0]   m_kill;
    int                   m_win;
    logic [N_REQ-1:0]     m_ready;
    int                   m_acc = 0;
    int                   dut_wb = 0;

    task automatic model_eval();
        m_kill = (bus.mispredict ? bus.flush_mask : '0) | mflush;
        m_win  = -1;
        if (!rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                int u;
                u = (mptr + k) % N_REQ;
                if (m_win < 0 && mv[u] && !m_kill[mr[u]]) m_win = u;
            end
        end
        for (int i = 0; i < N_REQ; i++)
            m_ready[i] = !mv[i] || (m_win == i) || m_kill[mr[i]];
    endtask

    task automatic model_compare();
        logic [N_REQ-1:0] eg;
        eg = (m_win >= 0) ? (N_REQ'(1) << m_win) : '0;
        check("model WB_valid", 64'(bus.WB_valid), 64'(m_win >= 0));
        check("model WB_grant", 64'(bus.WB_grant), 64'(eg));
        check("model WB_wen", 64'(bus.WB_wen), 64'(m_win >= 0 && mp[m_win >= 0 ? m_win : 0] != 0));
        if (!rst) check("model req_ready", 64'(bus.req_ready), 64'(m_ready));
        if (m_win >= 0) begin
            check("model WB_data", 64'(bus.WB_data), 64'(md[m_win]));
            check("model WB_rob_idx", 64'(bus.WB_rob_idx), 64'(mr[m_win]));
            check("model WB_P_rd", 64'(bus.WB_P_rd), 64'(mp[m_win]));
        end
    endtask

    task automatic model_update();
        logic [ROB_IDX_W-1:0] r;
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) mv[i] = 1'b0;
            mptr   = 0;
            mflush = '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && m_ready[i]) begin
                    r     = bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                    mv[i] = !m_kill[r];
                    md[i] = bus.req_data[i*XLEN +: XLEN];
                    mr[i] = r;
                    mp[i] = bus.req_P_rd[i*PREG_W +: PREG_W];
                    if (!m_kill[r]) m_acc++;
                end else if (m_win == i || m_kill[mr[i]]) begin
                    mv[i] = 1'b0;
                end
            end
            if (m_win >= 0) mptr = (m_win + 1) % N_REQ;
            if (bus.mispredict) mflush = bus.flush_mask;
            else if (!bus.stall) mflush = '0;
        end
    endtask

    // Inputs are set just after a falling edge; settle() samples before the rising edge.
    task automatic settle();
        #1;
        model_eval();
        model_compare();
        if (bus.WB_valid === 1'b1) dut_wb++;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_unit(input int i, input logic [XLEN-1:0] d,
                            input logic [ROB_IDX_W-1:0] r, input logic [PREG_W-1:0] p);
        bus.req_data[i*XLEN +: XLEN]               = d;
        bus.req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]  = r;
        bus.req_P_rd[i*PREG_W +: PREG_W]           = p;
    endtask

    task automatic idle_inputs();
        bus.req_valid   = '0;
        bus.req_data    = '0;
        bus.req_rob_idx = '0;
        bus.req_P_rd    = '0;
        bus.mispredict  = 1'b0;
        bus.flush_mask  = '0;
        bus.stall       = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic                        rst;
        logic [3:0]                  vld;
        logic [3:0][ROB_IDX_W-1:0]   rob;
        logic [PREG_W-1:0]           prd;
        logic                        misp;
        logic [ROB_LEN-1:0]          fmask;
        logic                        stall;
        logic                        e_valid;
        logic [3:0]                  e_grant;
        logic [ROB_IDX_W-1:0]        e_rob;
        logic                        e_wen;
        logic [3:0]                  e_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input logic r, input logic [3:0] vld,
                               input int r0, input int r1, input int r2, input int r3,
                               input int prd, input logic misp, input int fbit, input logic stall,
                               input logic ev, input logic [3:0] eg, input int erob,
                               input logic ew, input logic [3:0] erdy);
        vec_t v;
        v.rst     = r;
        v.vld     = vld;
        v.rob[0]  = ROB_IDX_W'(r0);
        v.rob[1]  = ROB_IDX_W'(r1);
        v.rob[2]  = ROB_IDX_W'(r2);
        v.rob[3]  = ROB_IDX_W'(r3);
        v.prd     = PREG_W'(prd);
        v.misp    = misp;
        v.fmask   = (fbit < 0) ? '0 : (ROB_LEN'(1) << fbit);
        v.stall   = stall;
        v.e_valid = ev;
        v.e_grant = eg;
        v.e_rob   = ROB_IDX_W'(erob);
        v.e_wen   = ew;
        v.e_ready = erdy;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] tbl_data(input int unit, input logic [ROB_IDX_W-1:0] r);
        return XLEN'(32'h5A00_0000 | (32'(unit) << 8) | 32'(r));
    endfunction

    initial begin
        vec_t v;
        int   gi;
        logic [3:0] exp_g;

        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < N_REQ; i++) begin
            mv[i] = 1'b0; md[i] = '0; mr[i] = '0; mp[i] = '0;
        end
        mptr = 0; mflush = '0;
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        settle();
        check("reset WB_valid", 64'(bus.WB_valid), 64'd0);
        check("reset WB_wen", 64'(bus.WB_wen), 64'd0);
        check("reset WB_grant", 64'(bus.WB_grant), 64'd0);
        check("reset req_ready", 64'(bus.req_ready), 64'hF);
        check("reset WB_data", 64'(bus.WB_data), 64'd0);
        check("reset WB_rob_idx", 64'(bus.WB_rob_idx), 64'd0);
        check("reset WB_P_rd", 64'(bus.WB_P_rd), 64'd0);
        advance();

        // Single result: one-cycle latency through the buffer.
        bus.req_valid = 4'b0001;
        set_unit(0, 32'hDEADBEEF, ROB_IDX_W'(3), PREG_W'(9));
        settle();
        check("single same-cycle WB_valid", 64'(bus.WB_valid), 64'd0);
        advance();
        idle_inputs();
        settle();
        check("single WB_valid", 64'(bus.WB_valid), 64'd1);
        check("single WB_rob_idx", 64'(bus.WB_rob_idx), 64'd3);
        check("single WB_data", 64'(bus.WB_data), 64'hDEADBEEF);
        check("single WB_P_rd", 64'(bus.WB_P_rd), 64'd9);
        check("single WB_wen", 64'(bus.WB_wen), 64'd1);
        check("single WB_grant", 64'(bus.WB_grant), 64'b0001);
        advance();
        settle();
        check("single after WB_valid", 64'(bus.WB_valid), 64'd0);
        advance();

        // Directed table: flush, stall-held flush, store, same-cycle kill, backpressure, reset.
        tbl.push_back(V(1,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0110, 0,5,7,0, 3, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 1, 7,0, 1,4'b0010,5,1,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 1, 4,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b1000, 0,0,0,4, 5, 0,-1,1, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b1000, 0,0,0,4, 5, 0,-1,1, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b1000, 0,0,0,4, 5, 0,-1,1, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b1000, 0,0,0,4, 5, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b1000,4,1,4'b1111));
        tbl.push_back(V(0,4'b0001, 9,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b0001,9,0,4'b1111));
        tbl.push_back(V(0,4'b0011,10,11,0,0,2, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 1,11,0, 1,4'b0001,10,1,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0011, 1,2,0,0, 1, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0011, 3,6,0,0, 1, 0,-1,0, 1,4'b0010,2,1,4'b1110));
        tbl.push_back(V(0,4'b0011, 3,8,0,0, 1, 0,-1,0, 1,4'b0001,1,1,4'b1101));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b0010,6,1,4'b1110));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b0001,3,1,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0111,12,13,14,0,1, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(1,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b1111, 1,2,3,4, 1, 0,-1,0, 0,4'b0000,0,0,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b0001,1,1,4'b0001));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b0010,2,1,4'b0011));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b0100,3,1,4'b0111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 1,4'b1000,4,1,4'b1111));
        tbl.push_back(V(0,4'b0000, 0,0,0,0, 0, 0,-1,0, 0,4'b0000,0,0,4'b1111));

        for (int t = 0; t < tbl.size(); t++) begin
            v = tbl[t];
            rst            = v.rst;
            bus.req_valid  = v.vld;
            for (int i = 0; i < 4; i++) set_unit(i, tbl_data(i, v.rob[i]), v.rob[i], v.prd);
            bus.mispredict = v.misp;
            bus.flush_mask = v.fmask;
            bus.stall      = v.stall;
            settle();
            check($sformatf("row%0d WB_valid", t), 64'(bus.WB_valid), 64'(v.e_valid));
            check($sformatf("row%0d WB_grant", t), 64'(bus.WB_grant), 64'(v.e_grant));
            if (!v.rst) check($sformatf("row%0d req_ready", t), 64'(bus.req_ready), 64'(v.e_ready));
            if (v.e_valid) begin
                gi = 0;
                exp_g = v.e_grant;
                for (int i = 0; i < 4; i++) if (exp_g[i]) gi = i;
                check($sformatf("row%0d WB_rob_idx", t), 64'(bus.WB_rob_idx), 64'(v.e_rob));
                check($sformatf("row%0d WB_data", t), 64'(bus.WB_data), 64'(tbl_data(gi, v.e_rob)));
                check($sformatf("row%0d WB_wen", t), 64'(bus.WB_wen), 64'(v.e_wen));
            end
            advance();
        end
        rst = 1'b0;
        idle_inputs();

        // All units streaming: strict rotation from pointer 0, nothing lost or duplicated.
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        begin
            int acc0, wb0;
            acc0 = m_acc;
            wb0  = dut_wb;
            for (int c = 0; c < 40; c++) begin
                bus.req_valid = 4'b1111;
                for (int i = 0; i < N_REQ; i++)
                    set_unit(i, XLEN'($urandom()), ROB_IDX_W'($urandom()), PREG_W'($urandom()));
                settle();
                if (c >= 1)
                    check($sformatf("rotate c%0d WB_grant", c), 64'(bus.WB_grant),
                          64'(4'b0001 << ((c - 1) % 4)));
                advance();
            end
            idle_inputs();
            for (int c = 0; c < 6; c++) begin
                settle();
                advance();
            end
            check("stream results delivered", 64'(dut_wb - wb0), 64'(m_acc - acc0));
        end

        // Randomized traffic with flushes, stalls and occasional reset.
        for (int c = 0; c < 400; c++) begin
            rst            = ($urandom_range(0, 49) == 0);
            bus.req_valid  = N_REQ'($urandom());
            for (int i = 0; i < N_REQ; i++)
                set_unit(i, XLEN'($urandom()), ROB_IDX_W'($urandom()),
                         ($urandom_range(0, 3) == 0) ? '0 : PREG_W'($urandom()));
            bus.mispredict = ($urandom_range(0, 9) == 0);
            bus.flush_mask = ROB_LEN'($urandom());
            bus.stall      = ($urandom_range(0, 2) == 0);
            settle();
            advance();
        end
        rst = 1'b0;
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single ROB/PRF writeback port (WB_valid/WB_data/WB_rob_idx) among N functional-unit result streams (ALU, MUL/DIV, LSU, FPU).
- Each requester has a 1-entry holding buffer. A round-robin arbiter selects one buffered result per cycle.
- Results belonging to squashed ROB entries (flush_mask) are dropped so they never reach the ROB or the PRF.
- Sits between FU writeback stages and the ROB/physical register file/wakeup logic.

Parameters:
- N_REQ, 4, number of requesting units (2..8).
- XLEN, 32, result data width.
- ROB_LEN, `ROB_LEN, ROB depth (power of two).
- ROB_IDX_W, $clog2(ROB_LEN), ROB index width.
- PREG_W, 7, physical register index width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-unit result valid.
- req_ready  out  N_REQ  per-unit accept; a transfer occurs when valid && ready.
- req_data  in  N_REQ*XLEN  result data, unit i in slice [i*XLEN +: XLEN].
- req_rob_idx  in  N_REQ*ROB_IDX_W  ROB index of each result.
- req_P_rd  in  N_REQ*PREG_W  destination physical register; 0 means no register write.
- mispredict  in  1  flush event this cycle.
- flush_mask  in  ROB_LEN  squash mask, valid when mispredict=1.
- stall  in  1  ROB in recovery; held flush mask stays active while high.
- WB_valid  out  1  writeback to ROB this cycle.
- WB_data  out  XLEN  winning result.
- WB_rob_idx  out  ROB_IDX_W  winning ROB index.
- WB_P_rd  out  PREG_W  winning destination register.
- WB_wen  out  1  PRF write enable = WB_valid && WB_P_rd != 0.
- WB_grant  out  N_REQ  one-hot winner (debug/konata).

Behaviour:
- State: buf_valid[i], buf_data/rob_idx/P_rd[i], rr_ptr (log2 N_REQ bits), flush_mask_r (ROB_LEN).
- Reset: buffers empty, rr_ptr=0, flush_mask_r=0. Consequently WB_valid=0, WB_wen=0, WB_grant=0, req_ready all 1. WB_data, WB_rob_idx and WB_P_rd are 0 because the selected buffer is cleared.
- Active mask: kill = (mispredict ? flush_mask : 0) | flush_mask_r.
- Flush mask register update, each cycle:
  - mispredict=1: flush_mask_r <= flush_mask.
  - else if stall=1: hold.
  - else: flush_mask_r <= 0.
- Eligibility: eligible[i] = buf_valid[i] && !kill[buf_rob_idx[i]].
- Grant is combinational: the first eligible index scanning rr_ptr, rr_ptr+1, … modulo N_REQ. At most one grant per cycle.
- WB outputs are combinational from the granted buffer. WB_valid = |grant. When no grant, the data outputs carry buffer 0 contents but are don't-care.
- Latency: a result accepted at edge t appears on WB in the cycle after t at the earliest. Throughput is 1 result per unit per cycle when that unit wins continuously.
- req_ready[i] = !buf_valid[i] || grant[i] || (buf_valid[i] && kill[buf_rob_idx[i]]). A killed buffer counts as free.
- Buffer update per i, at the edge:
  - On accept (valid && ready): if kill[req_rob_idx[i]], the buffer clears (the result is dropped). Otherwise the buffer loads the new result.
  - Otherwise, if granted or killed, the buffer clears.
  - Otherwise the buffer holds.
- rr_ptr: when WB_valid, rr_ptr <= (winner+1) mod N_REQ. Otherwise hold.
- Starvation bound: a continuously eligible buffer is granted within N_REQ cycles.
- A mispredict in the same cycle as the grant candidate: the killed candidate is not granted; the next eligible unit in round-robin order wins in that same cycle.
- Reset mid-operation: all buffered results are discarded, no WB pulse in the reset cycle or the following cycle.
- rob_idx values wrap naturally; no ordering between requesters is implied or enforced.

Decomposition:
- Package wb_pkg: typedef wb_req_t (data, rob_idx, P_rd) packed struct, parameterised widths via package localparams, and the kill-lookup function.
- Sub-module rr_arbiter (N-input round-robin, inputs req and ptr, outputs one-hot grant and winner index) is natural and reusable by the issue select logic.
- Buffers and the flush register stay in wb_arbiter.

Test Plan:
- Reset, then drive unit0 valid with data=0xDEADBEEF, rob_idx=3, P_rd=9 for one cycle -> next cycle WB_valid=1, WB_rob_idx=3, WB_data=0xDEADBEEF, WB_wen=1, WB_grant=0001; the cycle after, WB_valid=0.
- All 4 units valid every cycle with rr_ptr=0 -> grants 0,1,2,3,0…; each non-winning unit's req_ready is low while its buffer is full; no result lost or duplicated over 40 cycles.
- Buffered results: unit1 rob_idx=5, unit2 rob_idx=7. Assert mispredict with flush_mask bit7=1, bit5=0 -> unit1 granted; unit2 is never written back and its req_ready=1 next cycle.
- mispredict with flush_mask bit4=1, then stall=1 for 3 cycles; unit3 delivers rob_idx=4 during the stall -> dropped, WB_valid stays 0. After stall falls, rob_idx=4 is accepted and written back.
- Result with P_rd=0 (a store) -> WB_valid=1, WB_wen=0.
- Assert rst while 3 buffers are full -> WB_valid=0 in the reset cycle and the next cycle, req_ready=1111, rr_ptr back to 0.
